// File: rtl/conf_proto_pkg.sv
// Shared protocol constants, state encodings and helpers for the config frame controller.
package conf_proto_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned NBYTES      = 11;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned TMO_W       = 11;
    localparam int unsigned SLEDS_W     = 9;

    localparam logic [BYTE_W-1:0] SYNC   = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_WR = 8'h57;
    localparam logic [BYTE_W-1:0] CMD_RD = 8'h52;
    localparam logic [BYTE_W-1:0] ACK    = 8'h06;
    localparam logic [BYTE_W-1:0] NACK   = 8'h15;

    // Status LED bit positions
    localparam int unsigned LED_WR_OK   = 4;
    localparam int unsigned LED_CHK_ERR = 5;
    localparam int unsigned LED_TMO     = 6;
    localparam int unsigned LED_BAD_CMD = 7;
    localparam int unsigned LED_BUSY    = 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_DATA    = 4'd2,
        ST_CHK     = 4'd3,
        ST_LOAD    = 4'd4,
        ST_TXLD    = 4'd5,
        ST_TXSTART = 4'd6,
        ST_TXWAIT  = 4'd7,
        ST_TXDONE  = 4'd8,
        ST_RESP    = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        TXSEL_REGS = 2'd0,
        TXSEL_ACK  = 2'd1,
        TXSEL_NACK = 2'd2
    } txsel_t;

    typedef enum logic [1:0] {
        RESP_SEND = 2'd0,
        RESP_BUSY = 2'd1,
        RESP_DONE = 2'd2
    } resp_ph_t;

    // Sticky status flags, packed to line up with sleds[7:4]
    typedef struct packed {
        logic bad_cmd;
        logic tmo;
        logic chk_err;
        logic wr_ok;
    } flags_t;

    // Transmit byte mux: register image, or a response code
    function automatic logic [BYTE_W-1:0] tx_mux(input txsel_t sel, input logic [BYTE_W-1:0] regs);
        case (sel)
            TXSEL_ACK:  return ACK;
            TXSEL_NACK: return NACK;
            default:    return regs;
        endcase
    endfunction

endpackage

// File: rtl/conf_frame_timer.sv
// Inter-byte idle timer: counts while enabled, flags expiry at TIMEOUT_CYC-1.
module conf_frame_timer
    import conf_proto_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [TMO_W-1:0] tmo;

    // Idle cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        tmo <= '0;
        else if (clr)    tmo <= '0;
        else if (en)     tmo <= tmo + TMO_W'(1);
    end

    assign expire_c = en & ~clr & (tmo == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/conf_frame_ctrl.sv
// Frame parser / responder sequencing the config register bank over the serial link.
module conf_frame_ctrl
    import conf_proto_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  rxdw,
    input  logic               rxrdy,
    input  logic               txbusy,
    input  logic [BYTE_W-1:0]  regs_txdw,
    output logic               txena,
    output logic [BYTE_W-1:0]  txdw,
    output logic               shift_rxregs,
    output logic               load_confregs,
    output logic               load_txregs,
    output logic               shift_txregs,
    output logic [SLEDS_W-1:0] sleds
);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [BYTE_W-1:0]   chk, chk_n;
    logic [BYTE_W-1:0]   cmd, cmd_n;
    flags_t              flags, flags_n;
    txsel_t              tx_sel, tx_sel_n;
    resp_ph_t            resp_ph, resp_ph_n;
    logic                txena_n, shift_rx_n, load_conf_n, load_tx_n, shift_tx_n;
    logic                tmo_en, tmo_clr, expire_c;

    // Idle timeout only runs while a frame is being received
    assign tmo_en  = (state == ST_CMD) || (state == ST_DATA) || (state == ST_CHK);
    assign tmo_clr = rxrdy | ~tmo_en;

    conf_frame_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .expire_c (expire_c)
    );

    // State, datapath and strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            chk           <= '0;
            cmd           <= '0;
            flags         <= '0;
            tx_sel        <= TXSEL_REGS;
            resp_ph       <= RESP_SEND;
            txena         <= 1'b0;
            shift_rxregs  <= 1'b0;
            load_confregs <= 1'b0;
            load_txregs   <= 1'b0;
            shift_txregs  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            chk           <= chk_n;
            cmd           <= cmd_n;
            flags         <= flags_n;
            tx_sel        <= tx_sel_n;
            resp_ph       <= resp_ph_n;
            txena         <= txena_n;
            shift_rxregs  <= shift_rx_n;
            load_confregs <= load_conf_n;
            load_txregs   <= load_tx_n;
            shift_txregs  <= shift_tx_n;
        end
    end

    // Next-state and next-strobe logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        chk_n       = chk;
        cmd_n       = cmd;
        flags_n     = flags;
        tx_sel_n    = tx_sel;
        resp_ph_n   = resp_ph;
        txena_n     = 1'b0;
        shift_rx_n  = 1'b0;
        load_conf_n = 1'b0;
        load_tx_n   = 1'b0;
        shift_tx_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_sel_n = TXSEL_REGS;
                if (rxrdy && (rxdw == SYNC)) begin
                    state_n = ST_CMD;
                    flags_n = '0;
                    chk_n   = '0;
                end
            end
            ST_CMD: begin
                if (rxrdy) begin
                    cmd_n = rxdw;
                    chk_n = rxdw;
                    if (rxdw == CMD_WR) begin
                        state_n = ST_DATA;
                        cnt_n   = '0;
                    end else begin
                        state_n = ST_CHK;
                    end
                end
            end
            ST_DATA: begin
                if (rxrdy) begin
                    shift_rx_n = 1'b1;
                    chk_n      = chk ^ rxdw;
                    cnt_n      = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NBYTES - 1)) state_n = ST_CHK;
                end
            end
            ST_CHK: begin
                if (rxrdy) begin
                    if ((cmd != CMD_WR) && (cmd != CMD_RD)) begin
                        flags_n.bad_cmd = 1'b1;
                        tx_sel_n        = TXSEL_NACK;
                        resp_ph_n       = RESP_SEND;
                        state_n         = ST_RESP;
                    end else if (rxdw != chk) begin
                        flags_n.chk_err = 1'b1;
                        tx_sel_n        = TXSEL_NACK;
                        resp_ph_n       = RESP_SEND;
                        state_n         = ST_RESP;
                    end else if (cmd == CMD_WR) begin
                        load_conf_n = 1'b1;
                        state_n     = ST_LOAD;
                    end else begin
                        load_tx_n = 1'b1;
                        state_n   = ST_TXLD;
                    end
                end
            end
            ST_LOAD: begin
                flags_n.wr_ok = 1'b1;
                tx_sel_n      = TXSEL_ACK;
                resp_ph_n     = RESP_SEND;
                state_n       = ST_RESP;
            end
            ST_TXLD: begin
                cnt_n   = '0;
                state_n = ST_TXSTART;
            end
            ST_TXSTART: begin
                if (!txbusy) begin
                    txena_n = 1'b1;
                    state_n = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                if (txbusy) begin
                    shift_tx_n = 1'b1;
                    state_n    = ST_TXDONE;
                end
            end
            ST_TXDONE: begin
                if (!txbusy) begin
                    if (cnt == CNT_W'(NBYTES - 1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        state_n = ST_TXSTART;
                    end
                end
            end
            ST_RESP: begin
                case (resp_ph)
                    RESP_SEND: if (!txbusy) begin
                        txena_n   = 1'b1;
                        resp_ph_n = RESP_BUSY;
                    end
                    RESP_BUSY: if (txbusy) resp_ph_n = RESP_DONE;
                    default:   if (!txbusy) begin
                        tx_sel_n = TXSEL_REGS;
                        state_n  = ST_IDLE;
                    end
                endcase
            end
            default: state_n = ST_IDLE;
        endcase

        // Abandon a stalled frame without loading or answering
        if (expire_c) begin
            state_n     = ST_IDLE;
            flags_n.tmo = 1'b1;
        end
    end

    assign txdw  = tx_mux(tx_sel, regs_txdw);
    assign sleds = {(state != ST_IDLE), flags, state};

endmodule

// File: tb/tb_conf_frame_ctrl.sv
// Directed bench for conf_frame_ctrl with a simple transmitter and register-image model.
module tb_conf_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rxdw = 8'h00;
    logic       rxrdy = 1'b0;
    logic       txbusy = 1'b0;
    logic [7:0] regs_txdw;
    logic       txena;
    logic [7:0] txdw;
    logic       shift_rxregs, load_confregs, load_txregs, shift_txregs;
    logic [8:0] sleds;

    int checks = 0;
    int failures = 0;

    int n_shift_rx, n_load_conf, n_load_tx, n_shift_tx, n_txena;
    int busy_cnt = 0;
    logic [7:0] rx_log [0:31];
    logic [7:0] tx_log [0:31];
    logic [7:0] img [0:15];
    logic [3:0] tx_ptr = 4'd0;
    logic [7:0] pl [0:10];

    always #5 clk = ~clk;

    conf_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rxdw          (rxdw),
        .rxrdy         (rxrdy),
        .txbusy        (txbusy),
        .regs_txdw     (regs_txdw),
        .txena         (txena),
        .txdw          (txdw),
        .shift_rxregs  (shift_rxregs),
        .load_confregs (load_confregs),
        .load_txregs   (load_txregs),
        .shift_txregs  (shift_txregs),
        .sleds         (sleds)
    );

    assign regs_txdw = img[tx_ptr];

    // Strobe monitor, tx chain model and transmitter busy model
    always @(negedge clk) begin
        if (shift_rxregs) begin
            if (n_shift_rx < 32) rx_log[n_shift_rx] = rxdw;
            n_shift_rx++;
        end
        if (load_confregs) n_load_conf++;
        if (load_txregs) begin n_load_tx++; tx_ptr = 4'd0; end
        if (shift_txregs) begin n_shift_tx++; tx_ptr = tx_ptr + 4'd1; end
        if (txena) begin
            if (n_txena < 32) tx_log[n_txena] = txdw;
            n_txena++;
            txbusy = 1'b1;
            busy_cnt = 10;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) txbusy = 1'b0;
        end
    end

    task automatic clear_counts();
        n_shift_rx = 0; n_load_conf = 0; n_load_tx = 0; n_shift_tx = 0; n_txena = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxdw = b;
        rxrdy = 1'b1;
        @(negedge clk);
        rxrdy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_wr_frame(input logic [7:0] flip);
        logic [7:0] c;
        c = 8'h57;
        send_byte(8'hA5);
        send_byte(8'h57);
        for (int i = 0; i < 11; i++) begin
            send_byte(pl[i]);
            c = c ^ pl[i];
        end
        send_byte(c ^ flip);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!sleds[8]) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_idle_timeout: sleds=%03h still busy", name, sleds);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sleds !== 9'h000) begin failures++; $display("FAIL reset_sleds: got %03h want 000", sleds); end
        checks++;
        if ({txena, shift_rxregs, load_confregs, load_txregs, shift_txregs} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes: got %b want 00000",
                {txena, shift_rxregs, load_confregs, load_txregs, shift_txregs});
        end
        checks++;
        if (txdw !== img[0]) begin failures++; $display("FAIL reset_txdw: got %02h want %02h", txdw, img[0]); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_ok();
        int bad;
        for (int i = 0; i < 11; i++) pl[i] = 8'(i + 1);
        clear_counts();
        send_wr_frame(8'h00);
        wait_idle("write_ok");
        checks++;
        if (n_shift_rx != 11) begin failures++; $display("FAIL write_ok_shifts: got %0d want 11", n_shift_rx); end
        checks++;
        if (n_load_conf != 1) begin failures++; $display("FAIL write_ok_loads: got %0d want 1", n_load_conf); end
        checks++;
        if (n_txena != 1 || tx_log[0] !== 8'h06) begin
            failures++; $display("FAIL write_ok_ack: txena=%0d byte=%02h want 1/06", n_txena, tx_log[0]);
        end
        checks++;
        if (sleds !== 9'h010) begin failures++; $display("FAIL write_ok_sleds: got %03h want 010", sleds); end
        bad = 0;
        for (int i = 0; i < 11; i++) if (rx_log[i] !== 8'(i + 1)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL write_ok_rxdata: got %0d wrong bytes want 0", bad); end
    endtask

    task automatic test_write_badchk();
        clear_counts();
        send_wr_frame(8'h01);
        wait_idle("badchk");
        checks++;
        if (n_shift_rx != 11) begin failures++; $display("FAIL badchk_shifts: got %0d want 11", n_shift_rx); end
        checks++;
        if (n_load_conf != 0) begin failures++; $display("FAIL badchk_loads: got %0d want 0", n_load_conf); end
        checks++;
        if (n_txena != 1 || tx_log[0] !== 8'h15) begin
            failures++; $display("FAIL badchk_nack: txena=%0d byte=%02h want 1/15", n_txena, tx_log[0]);
        end
        checks++;
        if (sleds !== 9'h020) begin failures++; $display("FAIL badchk_sleds: got %03h want 020", sleds); end
    endtask

    task automatic test_read();
        int bad;
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h52);
        wait_idle("read");
        checks++;
        if (n_load_tx != 1) begin failures++; $display("FAIL read_load_tx: got %0d want 1", n_load_tx); end
        checks++;
        if (n_txena != 11 || n_shift_tx != 11) begin
            failures++; $display("FAIL read_tx_count: txena=%0d shift=%0d want 11/11", n_txena, n_shift_tx);
        end
        bad = 0;
        for (int i = 0; i < 11; i++) if (tx_log[i] !== img[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL read_tx_bytes: got %0d wrong bytes want 0", bad); end
        checks++;
        if (n_load_conf != 0 || sleds !== 9'h000) begin
            failures++; $display("FAIL read_side_effects: loads=%0d sleds=%03h want 0/000", n_load_conf, sleds);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (1990) @(negedge clk);
        checks++;
        if (sleds[8] !== 1'b1) begin failures++; $display("FAIL timeout_early: busy=%b want 1", sleds[8]); end
        repeat (60) @(negedge clk);
        checks++;
        if (sleds !== 9'h040) begin failures++; $display("FAIL timeout_sleds: got %03h want 040", sleds); end
        checks++;
        if (n_load_conf != 0 || n_txena != 0 || n_shift_rx != 3) begin
            failures++; $display("FAIL timeout_effects: loads=%0d txena=%0d shifts=%0d want 0/0/3",
                n_load_conf, n_txena, n_shift_rx);
        end
    endtask

    task automatic test_bad_cmd_and_sync_data();
        clear_counts();
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (sleds[8] !== 1'b0) begin failures++; $display("FAIL stray_ignored: busy=%b want 0", sleds[8]); end
        send_byte(8'hA5);
        send_byte(8'h33);
        send_byte(8'h33);
        wait_idle("badcmd");
        checks++;
        if (n_txena != 1 || tx_log[0] !== 8'h15) begin
            failures++; $display("FAIL badcmd_nack: txena=%0d byte=%02h want 1/15", n_txena, tx_log[0]);
        end
        checks++;
        if (sleds !== 9'h080) begin failures++; $display("FAIL badcmd_sleds: got %03h want 080", sleds); end
        for (int i = 0; i < 11; i++) pl[i] = 8'(8'h20 + i);
        pl[2] = 8'hA5;
        clear_counts();
        send_wr_frame(8'h00);
        wait_idle("syncdata");
        checks++;
        if (n_shift_rx != 11 || rx_log[2] !== 8'hA5) begin
            failures++; $display("FAIL syncdata_shift: shifts=%0d byte2=%02h want 11/a5", n_shift_rx, rx_log[2]);
        end
        checks++;
        if (n_load_conf != 1 || tx_log[0] !== 8'h06) begin
            failures++; $display("FAIL syncdata_ack: loads=%0d byte=%02h want 1/06", n_load_conf, tx_log[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 11; i++) pl[i] = 8'(8'h40 + i);
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h57);
        for (int i = 0; i < 6; i++) send_byte(pl[i]);
        @(negedge clk);
        rxdw = pl[6];
        rxrdy = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (sleds !== 9'h000) begin failures++; $display("FAIL midrst_sleds: got %03h want 000", sleds); end
        checks++;
        if ({txena, shift_rxregs, load_confregs, load_txregs, shift_txregs} !== 5'b0) begin
            failures++; $display("FAIL midrst_strobes: got %b want 00000",
                {txena, shift_rxregs, load_confregs, load_txregs, shift_txregs});
        end
        @(negedge clk);
        rxrdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (n_load_conf != 0) begin failures++; $display("FAIL midrst_noload: got %0d want 0", n_load_conf); end
        clear_counts();
        send_wr_frame(8'h00);
        wait_idle("postrst");
        checks++;
        if (n_load_conf != 1 || n_shift_rx != 11 || tx_log[0] !== 8'h06 || sleds !== 9'h010) begin
            failures++; $display("FAIL postrst_write: loads=%0d shifts=%0d byte=%02h sleds=%03h want 1/11/06/010",
                n_load_conf, n_shift_rx, tx_log[0], sleds);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h11 * (i + 1));
        clear_counts();
        test_reset();
        test_write_ok();
        test_write_badchk();
        test_read();
        test_timeout();
        test_bad_cmd_and_sync_data();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
